seq_booth_mult: RTL

Sequential radix-4 Booth multiplier with a start/busy/done handshake and runtime signed/unsigned mode. It retires two multiplier bits per cycle. It replaces the single-cycle combinational Booth wrapper in the multiplier datapath, trading latency for area at larger MBITS/NBITS. It sits between the operand registers and the accumulator stage.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/booth_radix4_recode.sv | 45 ++++
 rtl/seq_booth_mult.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
// Holds the FSM state encoding, the Booth digit set and the iteration count helper.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_e;

   function automatic int iter_count(input int nbits);
      return nbits / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_radix4_recode.sv
// Radix-4 Booth recoder: maps a multiplier bit triplet to a digit in {0,+-1,+-2}.
// Ports: triplet (3b), mpd (W-bit extended multiplicand) -> digit enum, addend (W bits).
module booth_radix4_recode
   import mult_pkg::*;
#(
   parameter int W = 14
) (
   input  logic [2:0]   triplet,
   input  logic [W-1:0] mpd,
   output booth_digit_e digit,
   output logic [W-1:0] addend
);

   logic [W-1:0] mpd_x2;

   assign mpd_x2 = {mpd[W-2:0], 1'b0};

   always_comb begin
      digit  = ZERO;
      addend = '0;
      unique case (triplet)
         3'b001, 3'b010: begin
            digit  = POS1;
            addend = mpd;
         end
         3'b011: begin
            digit  = POS2;
            addend = mpd_x2;
         end
         3'b100: begin
            digit  = NEG2;
            addend = -mpd_x2;
         end
         3'b101, 3'b110: begin
            digit  = NEG1;
            addend = -mpd;
         end
         default: begin
            digit  = ZERO;
            addend = '0;
         end
      endcase
   end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per cycle.
// Ports: clk, rst_n, start, signed_mode, mpd, mpr in; busy, done (1-cycle), prod out.
module seq_booth_mult
   import mult_pkg::*;
#(
   parameter int MBITS = 12,
   parameter int NBITS = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   signed_mode,
   input  logic [MBITS-1:0]       mpd,
   input  logic [NBITS-1:0]       mpr,
   output logic                   busy,
   output logic                   done,
   output logic [MBITS+NBITS-1:0] prod
);

   localparam int ITER = iter_count(NBITS);
   localparam int LW   = 2 * ITER;
   localparam int UW   = MBITS + 2;
   localparam int AW   = UW + LW;
   localparam int PW   = MBITS + NBITS;
   localparam int CW   = $clog2(ITER + 1);

   state_e          state_q, state_d;
   logic [UW-1:0]   mpd_q, mpd_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic            prev_q, prev_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   prod_q, prod_d;

   logic [UW-1:0]   mpd_ext;
   logic [LW-1:0]   mpr_ext;
   logic            mpr_sgn;
   logic [UW-1:0]   upper;
   logic [UW-1:0]   addend;
   logic [UW-1:0]   add_sel;
   logic [UW:0]     sum;
   logic [AW-1:0]   step_acc;
   booth_digit_e    digit;

   assign mpd_ext = signed_mode ? {{2{mpd[MBITS-1]}}, mpd}
                                : {2'b00, mpd};
   assign mpr_sgn = signed_mode & mpr[NBITS-1];
   assign mpr_ext = {{(LW-NBITS){mpr_sgn}}, mpr};

   // Low LW bits of acc hold the unconsumed multiplier bits; product
   // bits shift in from the top as the multiplier shifts out.
   booth_radix4_recode #(
      .W (UW)
   ) u_recode (
      .triplet (
         {acc_q[1], acc_q[0], prev_q}),
      .mpd     (mpd_q),
      .digit   (digit),
      .addend  (addend)
   );

   assign upper   = acc_q[AW-1:LW];
   assign add_sel = (digit == ZERO) ? '0 : addend;
   // One guard bit absorbs the transient |U + 2*mpd| growth before the
   // arithmetic shift brings the upper half back into UW bits.
   assign sum     = {upper[UW-1], upper}
                  + {add_sel[UW-1], add_sel};
   assign step_acc = {sum[UW], sum[UW:2],
                      sum[1:0], acc_q[LW-1:2]};

   always_comb begin
      state_d = state_q;
      mpd_d   = mpd_q;
      acc_d   = acc_q;
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               mpd_d   = mpd_ext;
               acc_d   = {{UW{1'b0}}, mpr_ext};
               prev_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            acc_d  = step_acc;
            prev_d = acc_q[1];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) begin
               prod_d  = step_acc[PW-1:0];
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mpd_q   <= '0;
         acc_q   <= '0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         mpd_q   <= mpd_d;
         acc_q   <= acc_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign prod = prod_q;

endmodule
